// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared constants for the manycore-link / AXI-Lite host bridge.
// Also holds the counter-width helper that the host FIFO serdes uses.
package bsg_manycore_link_to_axil_pkg;

  localparam int mcl_fifo_width_gp    = 128;
  localparam int mcl_word_width_gp    = 32;
  localparam int mcl_words_per_pkt_gp = 4;
  localparam int mcl_num_channels_gp  = 2;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int bsg_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_mcl_channel_serdes.sv
// One channel of the host FIFO serdes. The assembler packs host words into
// a packet, and the slicer unpacks a packet into host words, word 0 first.
module bsg_mcl_channel_serdes
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter  int fifo_width_p = mcl_fifo_width_gp,
  parameter  int word_width_p = mcl_word_width_gp,
  localparam int words_lp     = fifo_width_p / word_width_p,
  localparam int cnt_w_lp     = bsg_width(words_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    host_v_i,
  input  logic [word_width_p-1:0] host_data_i,
  output logic                    host_ready_o,
  input  logic                    host_clear_i,
  output logic [cnt_w_lp-1:0]     host_words_o,
  output logic                    fifo_v_o,
  output logic [fifo_width_p-1:0] fifo_data_o,
  input  logic                    fifo_ready_i,
  input  logic                    fifo_v_i,
  input  logic [fifo_width_p-1:0] fifo_data_i,
  output logic                    fifo_ready_o,
  output logic                    rx_v_o,
  output logic [word_width_p-1:0] rx_data_o,
  input  logic                    rx_ready_i,
  output logic [cnt_w_lp-1:0]     rx_words_o
);

  localparam int idx_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(words_lp);

  logic [cnt_w_lp-1:0]                      r_cnt;
  logic [cnt_w_lp-1:0]                      r_rem;
  logic [words_lp-1:0][word_width_p-1:0]    r_slots;
  logic [words_lp-1:0][word_width_p-1:0]    r_pkt;
  logic                                     w_host_hs;
  logic                                     w_pkt_hs;
  logic                                     w_cap;
  logic                                     w_rx_hs;
  logic [idx_w_lp-1:0]                      w_rd_idx;

  assign host_ready_o = (r_cnt != full_lp);
  assign fifo_v_o     = (r_cnt == full_lp);
  assign fifo_data_o  = r_slots;
  assign host_words_o = r_cnt;

  // A clear suppresses the word written in the same cycle.
  assign w_host_hs = host_v_i & host_ready_o & ~host_clear_i;
  assign w_pkt_hs  = fifo_v_o & fifo_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                        r_cnt <= '0;
    else if (host_clear_i | w_pkt_hs)   r_cnt <= '0;
    else if (w_host_hs)                 r_cnt <= r_cnt + cnt_w_lp'(1);
  end

  // NOTE: payload storage is deliberately unreset; only the counts are
  // architectural, so resetting wide data flops would buy nothing.
  always_ff @(posedge clk_i) begin
    if (w_host_hs) r_slots[idx_w_lp'(r_cnt)] <= host_data_i;
  end

  assign fifo_ready_o = (r_rem == '0);
  assign rx_v_o       = (r_rem != '0);
  assign rx_words_o   = r_rem;
  assign w_cap        = fifo_v_i & fifo_ready_o;
  assign w_rx_hs      = rx_v_o & rx_ready_i;
  assign w_rd_idx     = idx_w_lp'(full_lp - r_rem);
  assign rx_data_o    = r_pkt[w_rd_idx];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      r_rem <= '0;
    else if (w_cap)   r_rem <= full_lp;
    else if (w_rx_hs) r_rem <= r_rem - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (w_cap) r_pkt <= fifo_data_i;
  end

endmodule

// File: rtl/bsg_mcl_host_fifo_serdes.sv
// Host-side word/packet serdes: two independent channels, each converting
// host words to manycore packets and manycore packets back to host words.
module bsg_mcl_host_fifo_serdes
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter  int fifo_width_p = mcl_fifo_width_gp,
  parameter  int word_width_p = mcl_word_width_gp,
  localparam int words_lp     = fifo_width_p / word_width_p,
  localparam int cnt_w_lp     = bsg_width(words_lp)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   host_v_i,
  input  logic [1:0][word_width_p-1:0] host_data_i,
  output logic [1:0]                   host_ready_o,
  input  logic [1:0]                   host_clear_i,
  output logic [1:0][cnt_w_lp-1:0]     host_words_o,
  output logic [1:0]                   fifo_v_o,
  output logic [1:0][fifo_width_p-1:0] fifo_data_o,
  input  logic [1:0]                   fifo_ready_i,
  input  logic [1:0]                   fifo_v_i,
  input  logic [1:0][fifo_width_p-1:0] fifo_data_i,
  output logic [1:0]                   fifo_ready_o,
  output logic [1:0]                   rx_v_o,
  output logic [1:0][word_width_p-1:0] rx_data_o,
  input  logic [1:0]                   rx_ready_i,
  output logic [1:0][cnt_w_lp-1:0]     rx_words_o
);

  for (genvar c = 0; c < 2; c++) begin : g_chan
    bsg_mcl_channel_serdes #(
      .fifo_width_p(fifo_width_p),
      .word_width_p(word_width_p)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .host_v_i    (host_v_i[c]),
      .host_data_i (host_data_i[c]),
      .host_ready_o(host_ready_o[c]),
      .host_clear_i(host_clear_i[c]),
      .host_words_o(host_words_o[c]),
      .fifo_v_o    (fifo_v_o[c]),
      .fifo_data_o (fifo_data_o[c]),
      .fifo_ready_i(fifo_ready_i[c]),
      .fifo_v_i    (fifo_v_i[c]),
      .fifo_data_i (fifo_data_i[c]),
      .fifo_ready_o(fifo_ready_o[c]),
      .rx_v_o      (rx_v_o[c]),
      .rx_data_o   (rx_data_o[c]),
      .rx_ready_i  (rx_ready_i[c]),
      .rx_words_o  (rx_words_o[c])
    );
  end

endmodule

// File: tb/tb_bsg_mcl_host_fifo_serdes.sv
// Bench for bsg_mcl_host_fifo_serdes: directed tables, hand sequences and a
// randomized run against a queue-based model of both channels.
module tb_bsg_mcl_host_fifo_serdes;
  import bsg_manycore_link_to_axil_pkg::*;

  localparam int W  = mcl_word_width_gp;
  localparam int F  = mcl_fifo_width_gp;
  localparam int CW = bsg_width(mcl_words_per_pkt_gp);
  localparam logic [9:0] RST_STATUS = 10'b1_0_000_1_0_000;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          host_v, host_ready, host_clear, fifo_v_out, fifo_ready_in;
  logic [1:0]          fifo_v_in, fifo_ready_out, rx_v, rx_ready;
  logic [1:0][W-1:0]   host_data, rx_data;
  logic [1:0][F-1:0]   fifo_data_out, fifo_data_in;
  logic [1:0][CW-1:0]  host_words, rx_words;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_mcl_host_fifo_serdes dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .host_v_i    (host_v),
    .host_data_i (host_data),
    .host_ready_o(host_ready),
    .host_clear_i(host_clear),
    .host_words_o(host_words),
    .fifo_v_o    (fifo_v_out),
    .fifo_data_o (fifo_data_out),
    .fifo_ready_i(fifo_ready_in),
    .fifo_v_i    (fifo_v_in),
    .fifo_data_i (fifo_data_in),
    .fifo_ready_o(fifo_ready_out),
    .rx_v_o      (rx_v),
    .rx_data_o   (rx_data),
    .rx_ready_i  (rx_ready),
    .rx_words_o  (rx_words)
  );

  typedef struct {
    logic          hv;
    logic [W-1:0]  hd;
    logic          clr;
    logic          frdy;
    logic          e_rdy;
    logic [CW-1:0] e_words;
    logic          e_v;
    logic [F-1:0]  e_data;
  } asm_vec_t;

  asm_vec_t tbl[15];

  function automatic asm_vec_t mk(input logic hv, input logic [W-1:0] hd,
                                  input logic clr, input logic frdy,
                                  input logic e_rdy, input int e_words,
                                  input logic e_v, input logic [F-1:0] e_data);
    asm_vec_t v;
    v.hv = hv; v.hd = hd; v.clr = clr; v.frdy = frdy;
    v.e_rdy = e_rdy; v.e_words = CW'(e_words); v.e_v = e_v; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [F-1:0] act, input logic [F-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_v = '0; host_clear = '0; fifo_ready_in = '0;
    fifo_v_in = '0; rx_ready = '0;
  endtask

  function automatic logic [9:0] dut_status(input int c);
    return {host_ready[c], fifo_v_out[c], host_words[c],
            fifo_ready_out[c], rx_v[c], rx_words[c]};
  endfunction

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    check({tag, "_ch0"}, F'(dut_status(0)), F'(RST_STATUS));
    check({tag, "_ch1"}, F'(dut_status(1)), F'(RST_STATUS));
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [W-1:0] aq[2][$];
  logic [W-1:0] sq[2][$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0]   exp_st;
    logic [F-1:0] exp_pkt;
    logic [F-1:0] slice_pkt;
    logic         rr_seq[5];
    int           rw_seq[5];
    logic [W-1:0] rd_seq[5];
    int           pkts[2];
    int           words[2];

    idle();
    host_data = '0;
    fifo_data_in = '0;

    // Reset asserted mid-cycle from power-up.
    #12 rst = 1'b1;
    #1;
    check("reset_ch0", F'(dut_status(0)), F'(RST_STATUS));
    check("reset_ch1", F'(dut_status(1)), F'(RST_STATUS));
    tick();
    rst = 1'b0;
    tick();

    // Channel 0 assembler: fill, stall, drain, clear, clear-with-handshake.
    tbl[0]  = mk(1, 32'h11111111, 0, 0, 1, 1, 0, '0);
    tbl[1]  = mk(1, 32'h22222222, 0, 0, 1, 2, 0, '0);
    tbl[2]  = mk(1, 32'h33333333, 0, 0, 1, 3, 0, '0);
    tbl[3]  = mk(1, 32'h44444444, 0, 0, 0, 4, 1, 128'h44444444_33333333_22222222_11111111);
    tbl[4]  = mk(1, 32'h55555555, 0, 0, 0, 4, 1, 128'h44444444_33333333_22222222_11111111);
    tbl[5]  = mk(0, 32'h0,        0, 1, 1, 0, 0, '0);
    tbl[6]  = mk(1, 32'hA1A1A1A1, 0, 0, 1, 1, 0, '0);
    tbl[7]  = mk(1, 32'hA2A2A2A2, 0, 0, 1, 2, 0, '0);
    tbl[8]  = mk(1, 32'hDEADBEEF, 1, 0, 1, 0, 0, '0);
    tbl[9]  = mk(1, 32'hB0B0B0B0, 0, 0, 1, 1, 0, '0);
    tbl[10] = mk(1, 32'hB1B1B1B1, 0, 0, 1, 2, 0, '0);
    tbl[11] = mk(1, 32'hB2B2B2B2, 0, 0, 1, 3, 0, '0);
    tbl[12] = mk(1, 32'hB3B3B3B3, 0, 0, 0, 4, 1, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    tbl[13] = mk(0, 32'h0,        1, 1, 1, 0, 0, '0);
    tbl[14] = mk(0, 32'h0,        0, 1, 1, 0, 0, '0);

    for (int i = 0; i < 15; i++) begin
      host_v[0]        = tbl[i].hv;
      host_data[0]     = tbl[i].hd;
      host_clear[0]    = tbl[i].clr;
      fifo_ready_in[0] = tbl[i].frdy;
      tick();
      check($sformatf("asm_row%0d_ready", i), F'(host_ready[0]), F'(tbl[i].e_rdy));
      check($sformatf("asm_row%0d_words", i), F'(host_words[0]), F'(tbl[i].e_words));
      check($sformatf("asm_row%0d_fifo_v", i), F'(fifo_v_out[0]), F'(tbl[i].e_v));
      if (tbl[i].e_v) check($sformatf("asm_row%0d_data", i), fifo_data_out[0], tbl[i].e_data);
    end
    idle();

    // Channel 1 slicer with a one-cycle host stall.
    slice_pkt = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    rr_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rw_seq = '{3, 3, 2, 1, 0};
    rd_seq = '{32'h0000BBBB, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD, 32'h0};
    check("slice_ready_before", F'(fifo_ready_out[1]), F'(1'b1));
    fifo_v_in[1]    = 1'b1;
    fifo_data_in[1] = slice_pkt;
    tick();
    fifo_v_in[1] = 1'b0;
    check("slice_cap_rx_v", F'(rx_v[1]), F'(1'b1));
    check("slice_cap_words", F'(rx_words[1]), F'(4));
    check("slice_cap_data", F'(rx_data[1]), F'(32'h0000AAAA));
    check("slice_cap_fifo_ready", F'(fifo_ready_out[1]), F'(1'b0));
    for (int i = 0; i < 5; i++) begin
      rx_ready[1] = rr_seq[i];
      tick();
      check($sformatf("slice_step%0d_words", i), F'(rx_words[1]), F'(rw_seq[i]));
      check($sformatf("slice_step%0d_fifo_ready", i), F'(fifo_ready_out[1]), F'(rw_seq[i] == 0));
      if (rw_seq[i] != 0) check($sformatf("slice_step%0d_data", i), F'(rx_data[1]), F'(rd_seq[i]));
      else                check("slice_done_rx_v", F'(rx_v[1]), F'(1'b0));
    end
    idle();

    // Unthrottled throughput on all four paths.
    host_v = 2'b11; fifo_ready_in = 2'b11; fifo_v_in = 2'b11; rx_ready = 2'b11;
    pkts = '{0, 0};
    words = '{0, 0};
    for (int n = 0; n < 50; n++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        if (fifo_v_out[c]) pkts[c]++;
        if (rx_v[c]) words[c]++;
      end
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("thru_pkts_ch%0d", c), F'(pkts[c] >= 10), F'(1'b1));
      check($sformatf("thru_words_ch%0d", c), F'(words[c] >= 40), F'(1'b1));
    end

    // Randomized concurrent traffic against a queue model.
    async_reset("reset_pre_rand");
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 2; c++) begin
        exp_st = {aq[c].size() < 4, aq[c].size() == 4, CW'(aq[c].size()),
                  sq[c].size() == 0, sq[c].size() != 0, CW'(sq[c].size())};
        check($sformatf("rand_status_ch%0d_cyc%0d", c, n), F'(dut_status(c)), F'(exp_st));
        if (aq[c].size() == 4) begin
          exp_pkt = {aq[c][3], aq[c][2], aq[c][1], aq[c][0]};
          check($sformatf("rand_pkt_ch%0d_cyc%0d", c, n), fifo_data_out[c], exp_pkt);
        end
        if (sq[c].size() != 0)
          check($sformatf("rand_word_ch%0d_cyc%0d", c, n), F'(rx_data[c]), F'(sq[c][0]));

        host_v[c]        = ($urandom_range(0, 3) != 0);
        host_data[c]     = $urandom;
        host_clear[c]    = ($urandom_range(0, 63) == 0);
        fifo_ready_in[c] = ($urandom_range(0, 1) == 1);
        fifo_v_in[c]     = ($urandom_range(0, 1) == 1);
        fifo_data_in[c]  = {$urandom, $urandom, $urandom, $urandom};
        rx_ready[c]      = ($urandom_range(0, 2) != 0);

        if ((aq[c].size() == 4 && fifo_ready_in[c]) || host_clear[c]) aq[c].delete();
        else if (host_v[c] && aq[c].size() < 4) aq[c].push_back(host_data[c]);

        if (sq[c].size() == 0) begin
          if (fifo_v_in[c])
            for (int k = 0; k < 4; k++) sq[c].push_back(fifo_data_in[c][k*W +: W]);
        end else if (rx_ready[c]) begin
          void'(sq[c].pop_front());
        end
      end
      tick();
    end
    idle();

    // Reset with a partial assembly and unread slicer words.
    async_reset("reset_pre_mid");
    host_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      host_data[0] = 32'hC0C0C0C0 + k;
      tick();
    end
    host_v[0] = 1'b0;
    fifo_v_in[1] = 1'b1;
    fifo_data_in[1] = {$urandom, $urandom, $urandom, $urandom};
    tick();
    fifo_v_in[1] = 1'b0;
    rx_ready[1] = 1'b1;
    tick();
    tick();
    rx_ready[1] = 1'b0;
    check("mid_host_words", F'(host_words[0]), F'(3));
    check("mid_rx_words", F'(rx_words[1]), F'(2));
    async_reset("reset_mid_packet");
    for (int n = 0; n < 6; n++) begin
      tick();
      check($sformatf("post_reset_quiet%0d", n), F'({fifo_v_out, rx_v}), F'(4'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_mcl_host_fifo_serdes.md
# bsg_mcl_host_fifo_serdes

Host-side counterpart of the manycore endpoint-to-FIFO adapter. It converts two 32-bit host word streams into two 128-bit packet streams toward the manycore side: channel 0 carries host requests, channel 1 carries host responses. It also slices two 128-bit packet streams from the manycore side into 32-bit host words: channel 0 carries manycore responses, channel 1 carries manycore requests. It sits between the AXI-Lite register/FIFO logic and the 128-bit FIFO pair of the endpoint adapter, and provides per-channel word-occupancy status for host polling.

## Interface
Parameters:
- fifo_width_p, 128, packet width; must be a multiple of word_width_p
- word_width_p, 32, host word width
- words_lp, fifo_width_p/word_width_p (4), words per packet (localparam)

Ports (packet ports indexed [1:0] by channel):
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- host_v_i  in  [1:0]  host word valid (toward manycore)
- host_data_i  in  [1:0][word_width_p]  host word
- host_ready_o  out  [1:0]  assembler accepts a word
- host_clear_i  in  [1:0]  synchronous discard of assembler contents
- host_words_o  out  [1:0][`BSG_WIDTH(words_lp)]  words held in assembler (0..4)
- fifo_v_o  out  [1:0]  assembled packet valid
- fifo_data_o  out  [1:0][fifo_width_p]  assembled packet
- fifo_ready_i  in  [1:0]  downstream accepts packet
- fifo_v_i  in  [1:0]  packet valid from manycore side
- fifo_data_i  in  [1:0][fifo_width_p]  incoming packet
- fifo_ready_o  out  [1:0]  slicer empty, accepts packet
- rx_v_o  out  [1:0]  host word available
- rx_data_o  out  [1:0][word_width_p]  current word
- rx_ready_i  in  [1:0]  host consumes word
- rx_words_o  out  [1:0][`BSG_WIDTH(words_lp)]  words remaining in slicer (0..4)

## Operation
- Word order is little-endian: word k occupies bits [k*32 +: 32]. Word 0 is sent first and received first.
- Assembler (per channel):
  - Count register cnt, 0..words_lp.
  - host_ready_o = (cnt != words_lp).
  - On a host_v_i & host_ready_o handshake, the word is written to slot cnt and cnt increments.
  - fifo_v_o = (cnt == words_lp), and fifo_data_o is held stable while fifo_v_o is high.
  - On a fifo_v_o & fifo_ready_i handshake, cnt goes to 0.
  - host_clear_i forces cnt to 0 and blocks word acceptance that cycle.
  - If a packet handshake and host_clear_i occur in the same cycle, the packet counts as delivered and cnt goes to 0.
  - Slot data is not cleared; only cnt is architectural.
- Slicer (per channel):
  - Remaining count rem, 0..words_lp.
  - fifo_ready_o = (rem == 0).
  - On a handshake, the packet is captured and rem becomes words_lp.
  - rx_v_o = (rem != 0), and rx_data_o = word (words_lp - rem).
  - On an rx_v_o & rx_ready_i handshake, rem decrements.
  - Since fifo_ready_o is low while rem != 0, a new capture cannot collide with word consumption.
- host_words_o = cnt and rx_words_o = rem, both registered-state derived.
- The two channels and the two directions are fully independent; simultaneous activity on all four paths is legal.
- The block does no packet-content interpretation; request and response layouts are opaque.

## Timing
- Reset values, asynchronous assertion:
  - cnt = 0 and rem = 0.
  - host_ready_o = 1 and fifo_ready_o = 1.
  - fifo_v_o = 0, rx_v_o = 0, host_words_o = 0, rx_words_o = 0.
  - fifo_data_o and rx_data_o are don't-care.
- Assembler latency: fifo_v_o rises the cycle after the 4th word handshake. host_ready_o rises the cycle after the packet handshake. Peak throughput is 1 packet per 5 cycles per channel.
- Slicer latency: rx_v_o rises the cycle after the packet capture. fifo_ready_o rises the cycle after the last word handshake. Peak throughput is 1 packet per 5 cycles.
- No combinational path from any *_ready_i or *_v_i to any output.
- Reset mid-packet discards partial assemblies and unread slicer words; there is no recovery.

## Structure
- Shared constants go in bsg_manycore_link_to_axil_pkg:
  - mcl_fifo_width_gp = 128
  - mcl_word_width_gp = 32
  - mcl_words_per_pkt_gp = 4
- One natural sub-module is bsg_mcl_channel_serdes: one assembler plus one slicer, instantiated twice (index 0, index 1).
- Storage is flops. No SRAM and no external FIFO instance is needed.

## Test plan
- Reset: assert reset_i asynchronously mid-cycle -> all valids 0, both readies 1, host_words_o = 0, rx_words_o = 0 immediately.
- Assembly, channel 0: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles with fifo_ready_i = 0 -> fifo_data_o[0] = 0x44444444_33333333_22222222_11111111, host_ready_o[0] = 0, host_words_o[0] = 4. Then raise fifo_ready_i -> one-cycle handshake, host_ready_o[0] = 1 the next cycle.
- Slicing, channel 1: present 0xDDDD_CCCC_BBBB_AAAA (32-bit words 0x0000AAAA..0x0000DDDD, with zero upper halves), rx_ready_i toggling 1,0,1,1,1 -> words emitted in order AAAA, BBBB, CCCC, DDDD; rx_data_o stable during the stall; fifo_ready_o[1] returns to 1 one cycle after the last word.
- Clear: 2 words loaded, then host_clear_i[0] together with a host word -> host_words_o[0] = 0 next cycle, word dropped. Also clear coincident with a packet handshake -> packet delivered exactly once.
- Concurrency: random valid/ready on all four paths for 10k cycles against a scoreboard -> no loss, duplication or reordering; per-channel throughput ≥ 1 packet / 5 cycles when unthrottled.
- Reset mid-packet: 3 words assembled and 2 words left in the slicer, assert reset -> no fifo_v_o and no rx_v_o afterwards until new traffic.
